// File: rtl/pipe_stage_elastic_if.sv
// Valid/ready stream bundle for one side of an elastic pipeline stage.
// The master drives valid/data, the slave answers with ready.
interface pipe_stage_elastic_if #(
  parameter int WIDTH = 32
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_elastic.sv
// Elastic inter-stage register: DEPTH-entry circular skid buffer with valid/ready
// on both sides, synchronous flush and a saturating back-pressure counter.
module pipe_stage_elastic #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 2,
  parameter  int CNTW  = 16,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 flush,
  pipe_stage_elastic_if.slave  in_if,
  pipe_stage_elastic_if.master out_if,
  output logic [CW-1:0]        count,
  output logic [CNTW-1:0]      stall_cnt
);

  localparam logic [CW-1:0]   FULL      = CW'(DEPTH);
  localparam logic [PW-1:0]   LAST      = PW'(DEPTH - 1);
  localparam logic [CNTW-1:0] STALL_MAX = '1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q, rd_d;
  logic [PW-1:0]    wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNTW-1:0]  stall_q, stall_d;
  logic             in_ready, out_valid, push, pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  // Both handshake flags decode registered occupancy only, so ready never
  // depends combinationally on the downstream side.
  assign in_ready  = (cnt_q < FULL);
  assign out_valid = (cnt_q != '0);
  assign push      = in_if.valid & in_ready;
  assign pop       = out_valid & out_if.ready;

  assign in_if.ready  = in_ready;
  assign out_if.valid = out_valid;
  assign out_if.data  = out_valid ? mem_q[rd_q] : '0;
  assign count        = cnt_q;
  assign stall_cnt    = stall_q;

  // NOTE: every variable gets its hold value first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    stall_d = stall_q;

    // Stall accounting is independent of flush; only reset clears it.
    if (out_valid && !out_if.ready && (stall_q != STALL_MAX)) begin
      stall_d = stall_q + CNTW'(1);
    end

    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = ptr_inc(wr_q);
      if (pop)  rd_d = ptr_inc(rd_q);
      if (push && !pop) begin
        cnt_d = cnt_q + CW'(1);
      end else if (pop && !push) begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of evaluation order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  // NOTE: payload storage has no reset; the zero mask on out_data covers
  // empty entries, so only the occupancy state needs clearing.
  always_ff @(posedge CLK) begin
    if (push && !flush) begin
      mem_q[wr_q] <= in_if.data;
    end
  end

endmodule
